// File: rtl/sdes_rev_key_schedule_pkg.sv
// sdes_pkg: shared S-DES key-schedule widths, permutation tables, state type and helpers
package sdes_pkg;
  localparam int KEY_W = 10;
  localparam int HALF_W = 5;
  localparam int SUBKEY_W = 8;
  localparam int P10_TAB [KEY_W] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_TAB [SUBKEY_W] = '{6, 3, 7, 4, 8, 5, 10, 9};
  typedef enum logic [2:0] {IDLE, ROT_A, EMIT_K2, ROT_B, EMIT_K1} sdes_ks_state_t;
  // Position p (1-based, MSB first) lives at bit KEY_W-p.
  function automatic logic [KEY_W-1:0] perm_p10(input logic [KEY_W-1:0] k);
    logic [KEY_W-1:0] r;
    for (int i = 0; i < KEY_W; i++) r[KEY_W-1-i] = k[KEY_W-P10_TAB[i]];
    return r;
  endfunction
  function automatic logic [SUBKEY_W-1:0] perm_p8(input logic [KEY_W-1:0] k);
    logic [SUBKEY_W-1:0] r;
    for (int i = 0; i < SUBKEY_W; i++) r[SUBKEY_W-1-i] = k[KEY_W-P8_TAB[i]];
    return r;
  endfunction
endpackage

// File: rtl/sdes_rev_key_schedule_shift.sv
// circular_right_shift_reg: key half register with sync clear, load and rotate-right-by-1
module circular_right_shift_reg
  import sdes_pkg::*;
#(
  parameter int W = HALF_W
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         i_load,
  input  logic         i_rot,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  // Load wins over rotate; rotation moves each bit one place toward the LSB.
  always_ff @(posedge i_clk)
    if (!i_clr_n) o_q <= '0;
    else if (i_load) o_q <= i_d;
    else if (i_rot) o_q <= {o_q[0], o_q[W-1:1]};
endmodule

// File: rtl/sdes_rev_key_schedule.sv
// sdes_rev_key_schedule: emits S-DES subkeys K2 then K1; SDES_REV_KEY_SCHEDULE_ZEROIZE_EN clears halves after K1
module sdes_rev_key_schedule
  import sdes_pkg::*;
#(
  parameter int KEY_WIDTH = 10,
  parameter int SUBKEY_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [KEY_WIDTH-1:0]    i_key,
  input  logic                    i_key_valid,
  output logic                    o_key_ready,
  output logic [SUBKEY_WIDTH-1:0] o_subkey,
  output logic                    o_sk_sel,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy
);
  sdes_ks_state_t state_q;
  logic cnt_q;
  logic [HALF_W-1:0] l_q, r_q;
  logic [KEY_W-1:0] load_d;
  logic load, rot, zero;
  assign rot = state_q == ROT_A || state_q == ROT_B;
`ifdef SDES_REV_KEY_SCHEDULE_ZEROIZE_EN
  assign zero = state_q == EMIT_K1 && i_ready;
`else
  assign zero = 1'b0;
`endif
  assign load = (state_q == IDLE && i_key_valid) || zero;
  assign load_d = zero ? '0 : perm_p10(i_key);
  circular_right_shift_reg #(.W(HALF_W)) u_l (
    .i_clk(i_clk), .i_clr_n(i_rst_n), .i_load(load), .i_rot(rot),
    .i_d(load_d[KEY_W-1:HALF_W]), .o_q(l_q)
  );
  circular_right_shift_reg #(.W(HALF_W)) u_r (
    .i_clk(i_clk), .i_clr_n(i_rst_n), .i_load(load), .i_rot(rot),
    .i_d(load_d[HALF_W-1:0]), .o_q(r_q)
  );
  assign o_key_ready = state_q == IDLE;
  assign o_busy = state_q != IDLE;
  assign o_valid = state_q == EMIT_K2 || state_q == EMIT_K1;
  assign o_sk_sel = state_q == EMIT_K2;
  assign o_subkey = o_valid ? perm_p8({l_q, r_q}) : '0;
  // Sequencer: two right rotations before each emit, handshake advances out of an emit.
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= 1'b0;
    end else
      case (state_q)
        IDLE: if (i_key_valid) begin
          state_q <= ROT_A;
          cnt_q <= 1'b0;
        end
        ROT_A: begin
          cnt_q <= ~cnt_q;
          if (cnt_q) state_q <= EMIT_K2;
        end
        EMIT_K2: if (i_ready) begin
          state_q <= ROT_B;
          cnt_q <= 1'b0;
        end
        ROT_B: begin
          cnt_q <= ~cnt_q;
          if (cnt_q) state_q <= EMIT_K1;
        end
        EMIT_K1: if (i_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_sdes_rev_key_schedule.sv
// tb_sdes_rev_key_schedule: directed and random checks against a textbook S-DES key schedule model
module tb_sdes_rev_key_schedule;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [9:0] i_key = '0;
  logic i_key_valid = 1'b0;
  logic i_ready = 1'b1;
  logic o_key_ready, o_sk_sel, o_valid, o_busy;
  logic [7:0] o_subkey;
  int n_chk = 0;
  int n_err = 0;
  always #5 i_clk = ~i_clk;
  sdes_rev_key_schedule dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key(i_key), .i_key_valid(i_key_valid),
    .o_key_ready(o_key_ready), .o_subkey(o_subkey), .o_sk_sel(o_sk_sel),
    .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  // Textbook schedule: P10, split into halves, cumulative left shift s, then P8.
  function automatic logic [9:0] ref_halves(input logic [9:0] key, input int s);
    int p10t [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    logic q [10];
    logic [9:0] h;
    for (int i = 0; i < 10; i++) q[i] = key[10-p10t[i]];
    for (int i = 0; i < 5; i++) begin
      h[9-i] = q[(i+s)%5];
      h[4-i] = q[5+(i+s)%5];
    end
    return h;
  endfunction
  function automatic logic [7:0] ref_sk(input logic [9:0] key, input int s);
    int p8t [8] = '{6, 3, 7, 4, 8, 5, 10, 9};
    logic [9:0] h;
    logic [7:0] o;
    h = ref_halves(key, s);
    for (int j = 0; j < 8; j++) o[7-j] = h[10-p8t[j]];
    return o;
  endfunction
  task automatic check_idle(input string tag);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_kready"}, o_key_ready, 1'b1);
    check({tag, "_subkey"}, o_subkey, 8'h00);
  endtask
  task automatic run(input logic [9:0] key, input logic [7:0] k2, input logic [7:0] k1,
                     input int st2, input int st1, input bit glitch);
    logic [9:0] halves;
`ifdef SDES_REV_KEY_SCHEDULE_ZEROIZE_EN
    halves = '0;
`else
    halves = ref_halves(key, 1);
`endif
    i_key = key;
    i_key_valid = 1'b1;
    i_ready = st2 == 0;
    check("accept_kready", o_key_ready, 1'b1);
    tick;
    i_key_valid = glitch;
    if (glitch) i_key = 10'h3ff;
    check("rota1_busy", o_busy, 1'b1);
    check("rota1_valid", o_valid, 1'b0);
    tick;
    i_key_valid = 1'b0;
    check("rota2_valid", o_valid, 1'b0);
    check("rota2_kready", o_key_ready, 1'b0);
    tick;
    for (int c = 0; c < st2; c++) begin
      check("k2_hold", {o_valid, o_sk_sel, o_subkey}, {2'b11, k2});
      tick;
    end
    i_ready = 1'b1;
    check("k2", {o_valid, o_sk_sel, o_subkey}, {2'b11, k2});
    tick;
    i_ready = st1 == 0;
    check("rotb1_valid", o_valid, 1'b0);
    tick;
    check("rotb2_valid", o_valid, 1'b0);
    tick;
    for (int c = 0; c < st1; c++) begin
      check("k1_hold", {o_valid, o_sk_sel, o_subkey}, {2'b10, k1});
      tick;
    end
    i_ready = 1'b1;
    check("k1", {o_valid, o_sk_sel, o_subkey}, {2'b10, k1});
    tick;
    check_idle("done");
    check("halves", {dut.l_q, dut.r_q}, halves);
  endtask
  initial begin
    logic [9:0] k;
    tick;
    i_rst_n = 1'b1;
    check_idle("reset");
    check("reset_sel", o_sk_sel, 1'b0);
    check("reset_halves", {dut.l_q, dut.r_q}, 10'h000);
    run(10'b1010000010, 8'b01000011, 8'b10100100, 0, 0, 1'b0);
    run(10'b0000000000, 8'h00, 8'h00, 0, 0, 1'b0);
    run(10'b1111111111, 8'hff, 8'hff, 0, 0, 1'b0);
    run(10'b1010000010, 8'b01000011, 8'b10100100, 5, 0, 1'b0);
    run(10'b1010000010, 8'b01000011, 8'b10100100, 0, 2, 1'b1);
    i_key = 10'b1010000010;
    i_key_valid = 1'b1;
    tick;
    i_key_valid = 1'b0;
    tick;
    tick;
    tick;
    check("pre_rst_rotb", o_busy, 1'b1);
    i_rst_n = 1'b0;
    tick;
    i_rst_n = 1'b1;
    check_idle("midrst");
    for (int n = 0; n < 20; n++) begin
      k = 10'($urandom);
      run(k, ref_sk(k, 3), ref_sk(k, 1), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sdes_rev_key_schedule.md
# sdes_rev_key_schedule

Sequential S-DES key schedule that produces the two 8-bit round subkeys in decryption order, K2 first and then K1. It takes the 10-bit master key and applies P10. It then walks each 5-bit half with one-bit circular right shifts and applies P8 at each emit point. It sits in front of the S-DES round datapath when that datapath runs in decrypt mode.

## Interface
- KEY_WIDTH, 10, master key width; only 10 is supported.
- SUBKEY_WIDTH, 8, subkey width; only 8 is supported.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_key  in  KEY_WIDTH  master key; bit 9 is S-DES position 1.
- i_key_valid  in  1  key offered.
- o_key_ready  out  1  block can accept a key; high only in IDLE.
- o_subkey  out  SUBKEY_WIDTH  current subkey; bit 7 is position 1.
- o_sk_sel  out  1  1 = K2, 0 = K1; meaningful while o_valid is high.
- o_valid  out  1  o_subkey is valid.
- i_ready  in  1  consumer takes the subkey.
- o_busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ROT_A, EMIT_K2, ROT_B, EMIT_K1.
- Storage: left half L[4:0] and right half R[4:0], plus a 1-bit rotate counter.
- **IDLE**
  - o_key_ready=1.
  - When i_key_valid=1: {L,R} <= P10(i_key), with P10 = 3 5 2 7 4 10 1 9 8 6. Clear the counter and go to ROT_A.
- **ROT_A**
  - Each cycle, L and R each rotate right by 1: new[4]=old[0], new[i]=old[i+1].
  - After 2 rotations go to EMIT_K2. Right-rotate by 2 equals left-rotate by 3, which is the cumulative LS-1 plus LS-2 state.
- **EMIT_K2**
  - o_valid=1, o_sk_sel=1, o_subkey=P8({L,R}), with P8 = 6 3 7 4 8 5 10 9.
  - On o_valid&&i_ready go to ROT_B.
- **ROT_B**
  - 2 right rotations, same rule as ROT_A. This reaches the LS-1 state.
  - Then go to EMIT_K1.
- **EMIT_K1**
  - o_valid=1, o_sk_sel=0, o_subkey=P8({L,R}).
  - On o_valid&&i_ready go to IDLE.
- While not in IDLE, i_key_valid is ignored and the key is neither stored nor queued.
- Outputs are registered or decoded from state only; there is no combinational path from i_ready or i_key_valid to any output.

## Timing
- Reset is synchronous; on the first edge with i_rst_n=0:
  - state=IDLE, L=R=0, counter=0.
  - o_valid=0, o_sk_sel=0, o_subkey=0, o_busy=0, o_key_ready=1.
- Reset mid-operation, in any state, aborts with no further output. A pending subkey is dropped.
- The key is accepted in cycle 0, ROT_A occupies cycles 1–2, and K2 is valid from cycle 3.
- Backpressure:
  - K2 is held stable (value and o_sk_sel) for as long as i_ready=0.
  - ROT_B follows the K2 handshake cycle for 2 cycles, then K1 is valid.
- Minimum key-to-key period is 7 cycles, with i_ready held at 1.
  - The K1 handshake in cycle 6 returns the block to IDLE in cycle 7, where a new key can be accepted.
- If i_ready is high before o_valid, the handshake completes in the first valid cycle.

## Configuration
- Macro: SDES_REV_KEY_SCHEDULE_ZEROIZE_EN.
- Defined: on the K1 handshake edge, L and R are cleared to 0 along with the transition to IDLE. o_subkey reads 0 in IDLE.
- Undefined: L and R keep their last value in IDLE. o_subkey is still forced to 0 whenever o_valid=0.
- All other behaviour is identical in both builds.

## Structure
- Package sdes_pkg holds:
  - KEY_W=10, HALF_W=5, SUBKEY_W=8.
  - P10 and P8 index tables, as localparam arrays of positions 1..10.
  - The state enum typedef, sdes_ks_state_t.
- Sub-module circular_right_shift_reg: parameterized HALF_W register with synchronous active-low clear, a load port and a rotate-right-by-1 enable. It is instantiated twice, once for L and once for R.

## Test plan
- Key 1010000010 with i_ready=1: o_subkey=01000011 with o_sk_sel=1 in cycle 3, then 10100100 with o_sk_sel=0 in cycle 6. o_key_ready is high again in cycle 7.
- Keys 0000000000 and 1111111111: both subkeys are 00000000 and 11111111 respectively.
- Key 1010000010 with i_ready=0 for 5 cycles during EMIT_K2: o_subkey stays 01000011 and o_sk_sel stays 1. K1 appears 3 cycles after i_ready rises.
- i_key_valid pulsed with key 1111111111 during ROT_A of key 1010000010: the pulse is ignored, and the outputs are still 01000011 then 10100100.
- i_rst_n low for 1 cycle during ROT_B: the next cycle shows IDLE with o_valid=0, o_busy=0, o_key_ready=1. A new key then yields correct subkeys.
- With SDES_REV_KEY_SCHEDULE_ZEROIZE_EN defined: after the K1 handshake, L=R=00000 internally. With it undefined, L=00001 and R=11000.
